life_seq_ctrl: RTL

Controller that sequences the Game-of-Life cell array. It serially loads an initial pattern into the array. It issues generation-advance enables in free-run or single-step mode. It counts generations and halts on a generation limit, a STOP command, or a stable (unchanging) grid. It sits between the host command interface and the ROWS x COLS array of cells, driving the array's load/shift and generation-enable controls.

---
 rtl/life_pkg.sv | 31 +++
 rtl/life_seq_ctrl_tick.sv | 37 +++
 rtl/life_seq_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared types and constants for the Game-of-Life sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_STEP  = 3'd3,
        ST_CHECK = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    // Host command encodings
    localparam logic [1:0] CMD_LOAD = 2'd0;
    localparam logic [1:0] CMD_RUN  = 2'd1;
    localparam logic [1:0] CMD_STEP = 2'd2;
    localparam logic [1:0] CMD_STOP = 2'd3;

    // Number of cells shifted in during a LOAD
    function automatic int grid_cells(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage
`default_nettype wire

// File: rtl/life_seq_ctrl_tick.sv
`default_nettype none
// ============================================================================
//  Module      : life_tick
//  Description : RUN-mode prescaler. Counts 0..RUN_PERIOD-1 while enabled and
//                flags the terminal count; clear forces the count to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_tick #(
    parameter int RUN_PERIOD = 4
) (
    input  logic clk,
    input  logic _rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int               c_W    = $clog2(RUN_PERIOD);
    localparam logic [c_W-1:0]   c_LAST = c_W'(RUN_PERIOD - 1);

    logic [c_W-1:0] r_cnt;

    // Prescaler count, wrapping at the terminal value
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + c_W'(1);
        end
    end

    assign o_tc = i_en && (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/life_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : life_seq_ctrl
//  Description : Sequencer for the Game-of-Life cell array: serial pattern
//                load, free-run / single-step generation enables, generation
//                counting and halting on limit, STOP or a stable grid.
//  Revision    : 1.0 - initial release
// ============================================================================
module life_seq_ctrl
    import life_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int CNT_W      = 16,
    parameter int RUN_PERIOD = 4
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             load_valid,
    input  logic             load_bit,
    output logic             load_en,
    output logic             shift_bit,
    output logic             gen_en,
    input  logic             grid_changed,
    input  logic [CNT_W-1:0] gen_limit,
    output logic [CNT_W-1:0] gen_count,
    output logic             busy,
    output logic             stable,
    output logic             done
);

    localparam int                 c_GRID_CELLS = grid_cells(ROWS, COLS);
    localparam int                 c_BIT_W      = (c_GRID_CELLS > 1) ? $clog2(c_GRID_CELLS) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT   = c_BIT_W'(c_GRID_CELLS - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX    = '1;

    state_t             r_state;
    state_t             w_next;
    logic               r_live;        // high from the first clock after reset release
    logic               r_from_run;    // CHECK returns to RUN rather than IDLE
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_load_en;
    logic               r_shift_bit;
    logic [CNT_W-1:0]   r_gen_count;
    logic               r_stable;
    logic               r_done;

    logic w_cmd_ready;
    logic w_gen_en;
    logic w_tc;
    logic w_load_take;
    logic w_clr_counts;
    logic w_clr_flags;
    logic w_set_stable;
    logic w_set_done;

    // Prescaler runs only while in RUN and restarts from 0 on every entry
    life_tick #(
        .RUN_PERIOD (RUN_PERIOD)
    ) u_tick (
        .clk   (clk),
        ._rst  (_rst),
        .i_clr (r_state != ST_RUN),
        .i_en  (r_state == ST_RUN),
        .o_tc  (w_tc)
    );

    assign w_load_take = (r_state == ST_LOAD) && load_valid;

    // Next-state, command acceptance and generation-enable decode
    always_comb begin
        w_next       = r_state;
        w_cmd_ready  = 1'b0;
        w_gen_en     = 1'b0;
        w_clr_counts = 1'b0;
        w_clr_flags  = 1'b0;
        w_set_stable = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            ST_IDLE, ST_HALT: begin
                w_cmd_ready = r_live;
                if (cmd_valid && r_live) begin
                    case (cmd)
                        CMD_LOAD: begin
                            w_next       = ST_LOAD;
                            w_clr_counts = 1'b1;
                            w_clr_flags  = 1'b1;
                        end
                        CMD_RUN: begin
                            // A run that already hit its limit has nothing to do
                            if ((r_state == ST_HALT) && r_done && (gen_limit != '0) &&
                                (r_gen_count >= gen_limit)) begin
                                w_next = ST_HALT;
                            end else begin
                                w_next      = ST_RUN;
                                w_clr_flags = 1'b1;
                            end
                        end
                        CMD_STEP: begin
                            w_next = ST_STEP;
                        end
                        CMD_STOP: begin
                            w_next      = ST_IDLE;
                            w_clr_flags = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_load_take && (r_bit_cnt == c_LAST_BIT)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_cmd_ready = (cmd == CMD_STOP);
                // STOP wins over a coincident terminal count
                if (cmd_valid && (cmd == CMD_STOP)) begin
                    w_next = ST_IDLE;
                end else if (w_tc) begin
                    w_gen_en = 1'b1;
                    w_next   = ST_CHECK;
                end
            end
            ST_STEP: begin
                w_gen_en = 1'b1;
                w_next   = ST_CHECK;
            end
            ST_CHECK: begin
                if (!grid_changed) begin
                    w_set_stable = 1'b1;
                    w_next       = ST_HALT;
                end else if ((gen_limit != '0) && (r_gen_count == gen_limit)) begin
                    w_set_done = 1'b1;
                    w_next     = ST_HALT;
                end else if (r_from_run) begin
                    w_next = ST_RUN;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register plus the origin of the pending CHECK
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state    <= ST_IDLE;
            r_live     <= 1'b0;
            r_from_run <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (r_state != ST_CHECK) begin
                r_from_run <= (r_state == ST_RUN);
            end
        end
    end

    // Serial load path: registered shift enable/data and the cell counter
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_load_en   <= 1'b0;
            r_shift_bit <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            r_load_en <= w_load_take;
            if (w_load_take) begin
                r_shift_bit <= load_bit;
            end
            if (w_clr_counts) begin
                r_bit_cnt <= '0;
            end else if (w_load_take) begin
                r_bit_cnt <= (r_bit_cnt == c_LAST_BIT) ? '0 : r_bit_cnt + c_BIT_W'(1);
            end
        end
    end

    // Saturating generation counter and sticky halt-reason flags
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_gen_count <= '0;
            r_stable    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_clr_counts) begin
                r_gen_count <= '0;
            end else if (w_gen_en && (r_gen_count != c_CNT_MAX)) begin
                r_gen_count <= r_gen_count + CNT_W'(1);
            end
            if (w_clr_flags) begin
                r_stable <= 1'b0;
            end else if (w_set_stable) begin
                r_stable <= 1'b1;
            end
            if (w_clr_flags) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign load_en   = r_load_en;
    assign shift_bit = r_shift_bit;
    assign gen_en    = w_gen_en;
    assign gen_count = r_gen_count;
    assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN) ||
                       (r_state == ST_STEP) || (r_state == ST_CHECK);
    assign stable    = r_stable;
    assign done      = r_done;

endmodule
`default_nettype wire
